// File: rtl/pif_led_pattern.sv
`default_nettype none
// ============================================================================
//  Module      : pif_led_pattern
//  Description : Multi-channel LED pattern driver. Each channel holds an 8-bit
//                config register ([2:0] mode, [7:3] rate/duty R). The config
//                registers are written and read back over a strobe/addr/data
//                bus. A shared prescaled timebase produces a one-cycle tick.
//                The tick advances a rate counter in each channel. Supported
//                modes are OFF, ON, FLASH, ALT, PWM and BREATHE; modes 6 and 7
//                are reserved and drive the LED off.
//  Ports       : xclk       - system clock
//                sys_rst    - synchronous active-high reset
//                cfg_wr     - single-cycle config write strobe
//                cfg_addr   - channel index for write and readback
//                cfg_wdata  - config write data
//                cfg_rdata  - registered readback of cfg[cfg_addr]
//                             (0 when the address is out of range)
//                tick       - registered one-cycle timebase pulse
//                led        - registered LED drive, 1 = lit
//  Revision    : 1.0 - initial release
// ============================================================================
module pif_led_pattern #(
    parameter int NUM_LEDS = 2,
    parameter int PRESCALE = 16,
    parameter int PS_WIDTH = 24,
    parameter int AW       = 4
) (
    input  logic                xclk,
    input  logic                sys_rst,
    input  logic                cfg_wr,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [7:0]          cfg_wdata,
    output logic [7:0]          cfg_rdata,
    output logic                tick,
    output logic [NUM_LEDS-1:0] led
);

    localparam logic [2:0] c_MODE_ON      = 3'd1;
    localparam logic [2:0] c_MODE_FLASH   = 3'd2;
    localparam logic [2:0] c_MODE_ALT     = 3'd3;
    localparam logic [2:0] c_MODE_PWM     = 3'd4;
    localparam logic [2:0] c_MODE_BREATHE = 3'd5;

    localparam logic [PS_WIDTH-1:0] c_PS_LAST = PS_WIDTH'(PRESCALE - 1);

    logic [PS_WIDTH-1:0] r_ps;
    logic                r_tick;
    logic [4:0]          r_pwm;
    logic [7:0]          r_rdata;
    logic [NUM_LEDS-1:0] r_led;
    logic [NUM_LEDS-1:0] w_led_all;
    logic [7:0]          w_cfg_all [NUM_LEDS];
    logic [7:0]          w_rdata;

    // Shared timebase: the prescaler wraps every PRESCALE clocks and the tick
    // is registered, so it lands one cycle after the wrap value is reached.
    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            r_ps   <= '0;
            r_tick <= 1'b0;
            r_pwm  <= 5'd0;
        end else begin
            r_ps   <= (r_ps == c_PS_LAST) ? '0 : r_ps + 1'b1;
            r_tick <= (r_ps == c_PS_LAST);
            r_pwm  <= r_pwm + 5'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
        logic [7:0] r_cfg;
        logic [4:0] r_rcnt;
        logic       r_phase;
        logic [4:0] r_duty;
        logic       r_dir_down;
        logic       w_wr_hit;
        logic [2:0] w_mode;
        logic [4:0] w_rate;
        logic       w_led;

        assign w_wr_hit = cfg_wr && (cfg_addr == AW'(gi));
        assign w_mode   = r_cfg[2:0];
        assign w_rate   = r_cfg[7:3];

        // A write to this channel takes priority over a coincident tick, so
        // the pattern always restarts cleanly from the write.
        always_ff @(posedge xclk) begin
            if (sys_rst) begin
                r_cfg      <= 8'h00;
                r_rcnt     <= 5'd0;
                r_phase    <= 1'b0;
                r_duty     <= 5'd0;
                r_dir_down <= 1'b0;
            end else if (w_wr_hit) begin
                r_cfg      <= cfg_wdata;
                r_rcnt     <= 5'd0;
                r_phase    <= 1'b0;
                r_duty     <= 5'd0;
                r_dir_down <= 1'b0;
            end else if (r_tick) begin
                if (r_rcnt == w_rate) begin
                    r_rcnt  <= 5'd0;
                    r_phase <= ~r_phase;
                    // Breathe ramp: each endpoint is held for one step while
                    // the direction flips.
                    if (r_dir_down) begin
                        if (r_duty == 5'd0) begin
                            r_dir_down <= 1'b0;
                        end else begin
                            r_duty <= r_duty - 5'd1;
                        end
                    end else begin
                        if (r_duty == 5'd31) begin
                            r_dir_down <= 1'b1;
                        end else begin
                            r_duty <= r_duty + 5'd1;
                        end
                    end
                end else begin
                    r_rcnt <= r_rcnt + 5'd1;
                end
            end
        end

        always_comb begin
            w_led = 1'b0;
            case (w_mode)
                c_MODE_ON:      w_led = 1'b1;
                c_MODE_FLASH:   w_led = r_phase;
                c_MODE_ALT:     w_led = ~r_phase;
                c_MODE_PWM:     w_led = (r_pwm < w_rate);
                c_MODE_BREATHE: w_led = (r_pwm < r_duty);
                default:        w_led = 1'b0;
            endcase
        end

        assign w_led_all[gi] = w_led;
        assign w_cfg_all[gi] = r_cfg;
    end

    // Out-of-range addresses match no channel and read back as zero.
    always_comb begin
        w_rdata = 8'h00;
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (cfg_addr == AW'(i)) begin
                w_rdata = w_cfg_all[i];
            end
        end
    end

    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            r_rdata <= 8'h00;
            r_led   <= '0;
        end else begin
            r_rdata <= w_rdata;
            r_led   <= w_led_all;
        end
    end

    assign cfg_rdata = r_rdata;
    assign tick      = r_tick;
    assign led       = r_led;

endmodule
`default_nettype wire

// File: tb/tb_pif_led_pattern.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pif_led_pattern
//  Description : Self-checking bench for pif_led_pattern (PRESCALE=4,
//                NUM_LEDS=2). A closed-form reference model derives every
//                output from the clock count since reset, the last write edge
//                and the config of each channel. Literal checks pin reset,
//                tick timing, flash timing, PWM duty and readback behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pif_led_pattern;

    localparam int P  = 4;
    localparam int NL = 2;

    logic          xclk = 1'b0;
    logic          sys_rst;
    logic          cfg_wr;
    logic [3:0]    cfg_addr;
    logic [7:0]    cfg_wdata;
    logic [7:0]    cfg_rdata;
    logic          tick;
    logic [NL-1:0] led;

    pif_led_pattern #(
        .NUM_LEDS (NL),
        .PRESCALE (P),
        .PS_WIDTH (24),
        .AW       (4)
    ) dut (
        .xclk      (xclk),
        .sys_rst   (sys_rst),
        .cfg_wr    (cfg_wr),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .tick      (tick),
        .led       (led)
    );

    always #5 xclk = ~xclk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]    m_cfg [NL];
    int            m_w   [NL];
    int            m_c;
    logic [NL-1:0] exp_led;
    logic          exp_tick;
    logic [7:0]    exp_rdata;

    // LED value produced from the state that exists after clock edge c, for a
    // channel last written at edge w. Ticks are visible after every edge that
    // is a multiple of P and are consumed on the following edge; the tick
    // consumed on the write edge itself is lost.
    function automatic logic led_of(input logic [7:0] cfg, input int w, input int c);
        int lo, ticks, n_exp, m, duty, pwm, r;
        r     = int'(cfg[7:3]);
        pwm   = c % 32;
        lo    = (w < 1) ? 1 : w;
        ticks = (c - 1 >= lo) ? ((c - 1) / P - (lo - 1) / P) : 0;
        n_exp = ticks / (r + 1);
        m     = n_exp % 64;
        duty  = (m < 32) ? m : 63 - m;
        case (cfg[2:0])
            3'd1:    return 1'b1;
            3'd2:    return (n_exp % 2) == 1;
            3'd3:    return (n_exp % 2) == 0;
            3'd4:    return pwm < r;
            3'd5:    return pwm < duty;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge xclk) begin
        if (sys_rst) begin
            m_c = 0;
            for (int i = 0; i < NL; i++) begin
                m_cfg[i] = 8'h00;
                m_w[i]   = 0;
            end
            exp_led   = '0;
            exp_tick  = 1'b0;
            exp_rdata = 8'h00;
        end else begin
            for (int i = 0; i < NL; i++) exp_led[i] = led_of(m_cfg[i], m_w[i], m_c);
            exp_rdata = (int'(cfg_addr) < NL) ? m_cfg[int'(cfg_addr)] : 8'h00;
            m_c       = m_c + 1;
            exp_tick  = (m_c % P) == 0;
            if (cfg_wr && int'(cfg_addr) < NL) begin
                m_cfg[int'(cfg_addr)] = cfg_wdata;
                m_w[int'(cfg_addr)]   = m_c;
            end
        end
    end

    always @(negedge xclk) begin
        if (chk_en) begin
            check("model_led",   32'(led),       32'(exp_led));
            check("model_tick",  32'(tick),      32'(exp_tick));
            check("model_rdata", 32'(cfg_rdata), 32'(exp_rdata));
        end
    end

    // ---------------- stimulus ----------------
    task automatic wr(input int a, input logic [7:0] d);
        cfg_wr    = 1'b1;
        cfg_addr  = 4'(a);
        cfg_wdata = d;
        @(negedge xclk);
        cfg_wr    = 1'b0;
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge xclk);
            if (led[ch]) hi++;
        end
    endtask

    initial begin
        int cnt, hi;
        bit seen;
        sys_rst   = 1'b1;
        cfg_wr    = 1'b0;
        cfg_addr  = 4'd0;
        cfg_wdata = 8'h00;
        repeat (3) @(negedge xclk);

        // Reset state and first tick four edges after release.
        check("rst_led",   32'(led),       32'd0);
        check("rst_tick",  32'(tick),      32'd0);
        check("rst_rdata", 32'(cfg_rdata), 32'd0);
        sys_rst = 1'b0;
        chk_en  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge xclk);
            check("first_tick", 32'(tick), (k == 4) ? 32'd1 : 32'd0);
        end

        // ALT R=2 on ch1, then FLASH R=2 on ch0 written on a tick edge.
        wr(1, 8'h13);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge xclk);
            seen = tick;
        end
        check("tick_wait", 32'(seen), 32'd1);
        wr(0, 8'h12);
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge xclk);
            if (led[0]) seen = 1'b1;
            else cnt++;
        end
        check("flash_low_len", 32'(cnt), 32'd12);
        cnt = 1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge xclk);
            if (!led[0]) seen = 1'b1;
            else cnt++;
        end
        check("flash_high_len", 32'(cnt), 32'd12);

        // PWM duty over one 32-cycle window.
        wr(0, 8'h44);
        repeat (2) @(negedge xclk);
        count_high(0, 32, hi);
        check("pwm_r8", 32'(hi), 32'd8);
        wr(0, 8'h04);
        repeat (2) @(negedge xclk);
        count_high(0, 32, hi);
        check("pwm_r0", 32'(hi), 32'd0);
        wr(0, 8'hFC);
        repeat (2) @(negedge xclk);
        count_high(0, 32, hi);
        check("pwm_r31", 32'(hi), 32'd31);

        // Breathe R=0 on ch1 through more than a full up/down ramp.
        wr(1, 8'h05);
        repeat (600) @(negedge xclk);

        // Readback: old value on the write cycle, new value next cycle.
        wr(1, 8'h0B);
        check("rd_old", 32'(cfg_rdata), 32'h05);
        @(negedge xclk);
        check("rd_new", 32'(cfg_rdata), 32'h0B);
        wr(5, 8'hFF);
        check("rd_oor", 32'(cfg_rdata), 32'h00);

        // Reset in the middle of a breathe pattern.
        wr(0, 8'h05);
        cfg_addr = 4'd0;
        repeat (100) @(negedge xclk);
        sys_rst = 1'b1;
        @(negedge xclk);
        check("midrst_led",   32'(led),       32'd0);
        check("midrst_tick",  32'(tick),      32'd0);
        check("midrst_rdata", 32'(cfg_rdata), 32'd0);
        sys_rst = 1'b0;
        @(negedge xclk);
        check("midrst_cfg", 32'(cfg_rdata), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 2999) == 0) begin
                sys_rst = 1'b1;
            end else begin
                sys_rst = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) begin
                cfg_wr    = 1'b1;
                cfg_addr  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
                cfg_wdata = 8'($urandom);
                if ($urandom_range(0, 1) == 0) cfg_wdata[7:3] = 5'($urandom_range(0, 3));
            end else begin
                cfg_wr   = 1'b0;
                cfg_addr = 4'($urandom_range(0, 3));
            end
            @(negedge xclk);
        end
        sys_rst = 1'b0;
        cfg_wr  = 1'b0;
        @(negedge xclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
